// File: rtl/pes_pkg.sv
// Shared types and defaults for the packet event stretcher.
package pes_pkg;

    // Per-channel state; the encoding is fixed so debug taps read 0/1/2.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } ch_state_t;

    localparam int DEF_NUM_OUT     = 2;
    localparam int DEF_CNT_W       = 25;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_EVT_CNT_W   = 16;

    // LSB of channel ch inside the packed per-channel duration bus.
    function automatic int ch_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/pes_channel.sv
// One stretched output: IDLE -> ACTIVE (duration cycles) -> HOLDOFF -> IDLE,
// with optional retrigger and a sticky overrun flag.
module pes_channel
    import pes_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             evt,
    input  logic [CNT_W-1:0] duration,
    input  logic             retrig,
    input  logic [CNT_W-1:0] holdoff,
    input  logic             clr,
    output logic             pulse,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    ch_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovr_set;

    // State and counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter load/decrement and overrun detection.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ovr_set   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero duration disables the channel entirely.
                    if (evt && duration != '0) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = duration - ONE;
                    end
                end
                ACTIVE: begin
                    // Retrigger wins over expiry; a zero duration cannot
                    // retrigger, so the edge counts as an unserved one.
                    if (evt && retrig && duration != '0) begin
                        cnt_nxt = duration - ONE;
                    end else begin
                        ovr_set = evt;
                        if (cnt != '0) begin
                            cnt_nxt = cnt - ONE;
                        end else if (holdoff != '0) begin
                            state_nxt = HOLDOFF;
                            cnt_nxt   = holdoff - ONE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                HOLDOFF: begin
                    ovr_set = evt;
                    if (cnt != '0) begin
                        cnt_nxt = cnt - ONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Sticky overrun; a clear in the same cycle keeps only this cycle's event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (clr) begin
            overrun <= ovr_set;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end
    end

    assign pulse = (state == ACTIVE);

endmodule

// File: rtl/packet_event_stretcher.sv
// Packet-detected strobe front end (synchroniser + rising-edge detect),
// NUM_OUT independently timed stretched outputs and a saturating event count.
module packet_event_stretcher
    import pes_pkg::*;
#(
    parameter int NUM_OUT     = DEF_NUM_OUT,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int EVT_CNT_W   = DEF_EVT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     event_in,
    input  logic [NUM_OUT*CNT_W-1:0] duration,
    input  logic [NUM_OUT-1:0]       retrig_mask,
    input  logic [CNT_W-1:0]         holdoff,
    input  logic                     count_clr,
    output logic [NUM_OUT-1:0]       pulse_out,
    output logic                     busy,
    output logic [EVT_CNT_W-1:0]     event_count,
    output logic [NUM_OUT-1:0]       overrun
);

    localparam logic [EVT_CNT_W-1:0] EVT_ONE = EVT_CNT_W'(1);

    logic sync_lvl;
    logic prev_q;
    logic evt_q;
    logic evt;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Metastability chain; runs even while disabled so a level that
            // is already high when en rises is not mistaken for a new edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= event_in;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign sync_lvl = sync_q[SYNC_STAGES-1];
        end else begin : g_bypass
            assign sync_lvl = event_in;
        end
    endgenerate

    // Edge detect; the event strobe is registered so the output latency is
    // SYNC_STAGES+1 edges from the first sample of event_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            prev_q <= sync_lvl;
            evt_q  <= sync_lvl & ~prev_q & en;
        end
    end

    // Gate again so an en drop in the strobe cycle suppresses the event.
    assign evt = evt_q & en;

    // Saturating accepted-edge counter; clear and a same-cycle event give 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_count <= '0;
        end else if (count_clr) begin
            event_count <= EVT_CNT_W'(evt);
        end else if (evt && event_count != '1) begin
            event_count <= event_count + EVT_ONE;
        end
    end

    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
            pes_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .evt     (evt),
                .duration(duration[ch_lsb(i, CNT_W) +: CNT_W]),
                .retrig  (retrig_mask[i]),
                .holdoff (holdoff),
                .clr     (count_clr),
                .pulse   (pulse_out[i]),
                .overrun (overrun[i])
            );
        end
    endgenerate

    assign busy = |pulse_out;

endmodule

// File: doc/packet_event_stretcher.md
Name: packet_event_stretcher

Overview:
Parametrised multi-output pulse stretcher/trigger generator driven by the Packet_Sniffer packet_detected strobe. It synchronises and edge-detects the strobe, then drives NUM_OUT independently timed output pulses (LED indicator, scope trigger, and future outputs). Each output has its own runtime duration, a retrigger mode and a global post-pulse holdoff. It also keeps a saturating packet counter and per-output sticky overrun flags for debug.

Parameters:
NUM_OUT, 2, number of stretched outputs/channels
CNT_W, 25, width of each duration/holdoff counter (max 2^CNT_W-1 cycles)
SYNC_STAGES, 2, synchroniser flops on event_in; 0 = bypass (event_in already in clk domain)
EVT_CNT_W, 16, width of the packet event counter

Ports:
clk  in  1  16 MHz system clock
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; low aborts all pulses and ignores events
event_in  in  1  packet_detected level/strobe (may be from symbol-clock domain)
duration  in  NUM_OUT*CNT_W  per-channel pulse length in clk cycles, channel i at [i*CNT_W +: CNT_W]
retrig_mask  in  NUM_OUT  1 = channel i is retriggerable
holdoff  in  CNT_W  cycles each channel ignores events after its pulse ends
count_clr  in  1  synchronous clear of event_count and overrun
pulse_out  out  NUM_OUT  stretched pulses
busy  out  1  OR of pulse_out
event_count  out  EVT_CNT_W  accepted rising edges, saturating
overrun  out  NUM_OUT  sticky: an edge arrived while channel i was not IDLE and was not retriggered

Behaviour:
- Reset (rst=0, async): sync chain, edge flop, all counters 0; all channels IDLE; pulse_out=0, busy=0, event_count=0, overrun=0.
- Front end: event_in -> SYNC_STAGES flops -> prev flop; evt = sync & ~prev (one-cycle pulse per rising edge). A held-high event_in yields exactly one evt. evt is gated by en.
- Latency: event_in first sampled high at edge 0 -> evt asserted during cycle SYNC_STAGES -> pulse_out registered high at edge SYNC_STAGES+1.
- Per-channel FSM (registered pulse_out = state==ACTIVE):
  IDLE: evt and duration_i!=0 -> ACTIVE, cnt<=duration_i-1. duration_i==0 -> channel disabled, stays IDLE, no overrun.
  ACTIVE: cnt!=0 -> cnt-1. cnt==0 -> HOLDOFF with cnt<=holdoff-1 if holdoff!=0, else IDLE. Pulse width is exactly duration_i cycles.
  ACTIVE + evt, retrig_mask[i]=1: cnt<=duration_i-1 (takes priority over expiry); pulse ends duration_i cycles after the last edge.
  ACTIVE + evt, retrig_mask[i]=0: ignored, overrun[i]<=1.
  HOLDOFF: pulse_out low; evt ignored, overrun[i]<=1; cnt==0 -> IDLE. An evt on the final HOLDOFF cycle is ignored.
- duration/holdoff are sampled only on load; changes mid-pulse do not affect the running count.
- en=0: all channels -> IDLE next edge, pulse_out low, counters 0; evt suppressed (not counted, no overrun). Sync chain keeps running, so an event_in already high when en rises gives no evt.
- event_count: +1 per gated evt, saturates at all-ones. count_clr clears count and overrun; count_clr with evt in the same cycle -> count=1, and overrun reflects only that cycle's event.
- busy = |pulse_out (combinational from registers).
- Widths: all counters unsigned, no wrap; decrement only when cnt!=0.

Decomposition:
- Package pes_pkg: channel state enum {IDLE, ACTIVE, HOLDOFF} (2-bit encoding 0/1/2) and default parameter constants. The channel slice helper is a localparam/function of CNT_W.
- Sub-module pes_channel: one FSM + CNT_W counter + overrun bit. Ports: clk, rst, en, evt, duration, retrig, holdoff, clr, pulse, overrun. Generated NUM_OUT times. Top keeps the synchroniser, edge detect, event_count and busy.

Test Plan:
- Basic: SYNC_STAGES=2, duration0=5, holdoff=0, single event_in pulse -> pulse_out[0] rises at edge 3 and is high exactly 5 cycles; event_count=1; overrun=0.
- Retrigger: duration1=10, retrig_mask[1]=1, edges at t=0 and t=6 -> pulse_out[1] high 16 cycles total; non-retrig channel0 (duration 10) high 10 cycles and overrun[0]=1.
- Holdoff: duration0=4, holdoff=8, edges 6 and 14 cycles after the first -> 2nd ignored (overrun[0]=1), 3rd starts a new pulse; event_count=3.
- Edge cases: event_in held high 100 cycles -> one pulse, count=1; duration_i=0 -> that output never rises; count_clr with simultaneous evt -> event_count=1.
- Abort/reset: en dropped mid-pulse -> pulse_out low next edge, later edges not counted; rst asserted mid-pulse -> all outputs 0 immediately (async).
- Saturation: EVT_CNT_W=4, 20 separate edges -> event_count holds 15.
